imem_load_ctrl: RTL

//  Owns the write side and the fetch gating of the 256x32 instruction memory.

---
 rtl/imem_load_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: streams a program into the instruction memory, then gates core fetch
// Ports: clk/rst (async active-high); load_start/load_len/go start a load or release the core;
//  s_valid/s_data/s_ready carry the loader word stream; pc/instr/cpu_stall face the core;
//  mem_we/mem_wa/mem_wd/mem_ra/mem_rd drive the sync-write, async-read array;
//  load_done/words_loaded/checksum report the load; err_pc flags an illegal fetch and stays set.
module imem_load_ctrl #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int AUTO_RUN = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              go,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [31:0]       mem_wd,
  output logic [ADDR_W-1:0] mem_ra,
  input  logic [31:0]       mem_rd,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       checksum,
  output logic              err_pc
);
  localparam logic [1:0] HALT = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [1:0] state;
  logic [ADDR_W:0] len_q;
  logic beat, fin, bad;
  assign cpu_stall = state != RUN;
  // ready drops once the requested count is met, so a zero-length load takes no beats
  assign s_ready = state == LOAD && words_loaded != len_q;
  assign beat = s_valid & s_ready;
  assign fin = state == LOAD && (words_loaded == len_q || (beat && words_loaded + (ADDR_W+1)'(1) == len_q));
  assign bad = pc[1:0] != 2'b0 || pc[31:ADDR_W+2] != '0;
  assign mem_we = beat;
  assign mem_wa = words_loaded[ADDR_W-1:0];
  assign mem_wd = s_data;
  assign mem_ra = pc[ADDR_W+1:2];
  assign instr = !cpu_stall && !bad ? mem_rd : NOP_WORD;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HALT;
      len_q <= '0;
      words_loaded <= '0;
      checksum <= '0;
      err_pc <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= fin;
      if (state != LOAD && load_start) begin
        state <= LOAD;
        len_q <= load_len > DEPTH_L ? DEPTH_L : load_len;
        words_loaded <= '0;
        checksum <= '0;
        err_pc <= 1'b0;
      end else begin
        err_pc <= err_pc | (state == RUN && bad);
        if (beat) begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          checksum <= checksum + s_data;
        end
        if (fin) state <= AUTO_RUN != 0 ? RUN : HALT;
        else if (state == HALT && go) state <= RUN;
      end
    end
  end
endmodule
